// File: rtl/ddr_train_pkg.sv
// Shared types and helpers for the DDR3 PHY per-lane training engines.
// Holds the trainer FSM state type, delay direction codes and tap arithmetic.
package ddr_train_pkg;

    localparam int TAP_W = 8;

    typedef logic [TAP_W-1:0] tap_t;
    typedef logic [TAP_W:0]   len_t;

    localparam logic DIR_INC = 1'b1;
    localparam logic DIR_DEC = 1'b0;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_LOAD,
        ST_CLEAR,
        ST_SETTLE,
        ST_SAMPLE,
        ST_STEP,
        ST_CALC,
        ST_RETURN,
        ST_FINISH
    } state_e;

    // Floor centre of a window; the extra bit keeps start + half from wrapping.
    function automatic tap_t calc_center(input tap_t start, input len_t len);
        len_t half;
        len_t sum;
        if (len == len_t'(1'b0)) begin
            half = len_t'(1'b0);
        end else begin
            half = (len - len_t'(1'b1)) >> 1'b1;
        end
        sum = {1'b0, start} + half;
        return sum[TAP_W-1:0];
    endfunction

endpackage

// File: rtl/dq_read_eye_trainer_if.sv
// Sequencer handshake plus the IOD delay-line / eye-monitor lane seen by one trainer.
// master = trainer side, slave = sequencer/IOD side.
interface dq_read_eye_trainer_if;
    import ddr_train_pkg::*;

    logic START;
    logic BUSY;
    logic DONE;
    logic FAIL;
    tap_t TAP_CENTER;
    tap_t WINDOW_LEN;
    logic EYE_MONITOR_EARLY_0;
    logic EYE_MONITOR_LATE_0;
    logic EYE_MONITOR_CLEAR_FLAGS_0;
    logic DELAY_LINE_LOAD_0;
    logic DELAY_LINE_MOVE_0;
    logic DELAY_LINE_DIRECTION_0;
    logic DELAY_LINE_OUT_OF_RANGE_0;

    modport master (
        input  START, EYE_MONITOR_EARLY_0, EYE_MONITOR_LATE_0, DELAY_LINE_OUT_OF_RANGE_0,
        output BUSY, DONE, FAIL, TAP_CENTER, WINDOW_LEN,
               EYE_MONITOR_CLEAR_FLAGS_0, DELAY_LINE_LOAD_0, DELAY_LINE_MOVE_0,
               DELAY_LINE_DIRECTION_0
    );

    modport slave (
        output START, EYE_MONITOR_EARLY_0, EYE_MONITOR_LATE_0, DELAY_LINE_OUT_OF_RANGE_0,
        input  BUSY, DONE, FAIL, TAP_CENTER, WINDOW_LEN,
               EYE_MONITOR_CLEAR_FLAGS_0, DELAY_LINE_LOAD_0, DELAY_LINE_MOVE_0,
               DELAY_LINE_DIRECTION_0
    );

endinterface

// File: rtl/dq_read_eye_trainer_window_tracker.sv
// Run/best passing-window bookkeeping for the read-eye sweep and the centre of the best window.
// Strictly-longer runs replace the best, so on a tie the earlier window is kept.
module train_window_tracker
    import ddr_train_pkg::*;
(
    input  logic clk_i,
    input  logic rst_ni,
    input  logic init_i,
    input  logic sample_i,
    input  logic pass_i,
    input  logic close_i,
    input  tap_t cur_tap_i,
    output tap_t best_start_o,
    output len_t best_len_o,
    output tap_t center_o
);

    tap_t run_start_q, run_start_d;
    len_t run_len_q, run_len_d;
    tap_t best_start_q, best_start_d;
    len_t best_len_q, best_len_d;
    tap_t eff_start_s;
    len_t eff_len_s;

    // Fold the current sample into the open run, then close it on a fail or at sweep end.
    always_comb begin
        run_start_d  = run_start_q;
        run_len_d    = run_len_q;
        best_start_d = best_start_q;
        best_len_d   = best_len_q;
        eff_start_s  = run_start_q;
        eff_len_s    = run_len_q;
        if (pass_i) begin
            eff_len_s = run_len_q + len_t'(1'b1);
            if (run_len_q == len_t'(1'b0)) begin
                eff_start_s = cur_tap_i;
            end else begin
                eff_start_s = run_start_q;
            end
        end else begin
            eff_len_s = run_len_q;
        end
        if (init_i) begin
            run_start_d  = tap_t'(1'b0);
            run_len_d    = len_t'(1'b0);
            best_start_d = tap_t'(1'b0);
            best_len_d   = len_t'(1'b0);
        end else if (sample_i) begin
            if (pass_i && !close_i) begin
                run_start_d = eff_start_s;
                run_len_d   = eff_len_s;
            end else begin
                if (eff_len_s > best_len_q) begin
                    best_start_d = eff_start_s;
                    best_len_d   = eff_len_s;
                end else begin
                    best_len_d = best_len_q;
                end
                run_len_d = len_t'(1'b0);
            end
        end else begin
            run_len_d = run_len_q;
        end
    end

    // Window state registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            run_start_q  <= tap_t'(1'b0);
            run_len_q    <= len_t'(1'b0);
            best_start_q <= tap_t'(1'b0);
            best_len_q   <= len_t'(1'b0);
        end else begin
            run_start_q  <= run_start_d;
            run_len_q    <= run_len_d;
            best_start_q <= best_start_d;
            best_len_q   <= best_len_d;
        end
    end

    assign best_start_o = best_start_q;
    assign best_len_o   = best_len_q;
    assign center_o     = calc_center(best_start_q, best_len_q);

endmodule

// File: rtl/dq_read_eye_trainer.sv
// Per-lane DQ read-eye trainer: sweeps the IOD input delay, finds the longest passing window
// and parks the delay line at its centre.
module dq_read_eye_trainer
    import ddr_train_pkg::*;
#(
    parameter int MAX_TAPS      = 128,
    parameter int SETTLE_CYCLES = 8,
    parameter int MOVE_GAP      = 4,
    parameter int MIN_WINDOW    = 4
) (
    input  logic FAB_CLK,
    input  logic ARST_N,
    dq_read_eye_trainer_if.master bus
);

    localparam tap_t        LAST_TAP    = tap_t'(MAX_TAPS - 1);
    localparam len_t        MIN_LEN     = len_t'(MIN_WINDOW);
    localparam logic [15:0] SETTLE_INIT = 16'(SETTLE_CYCLES - 1);
    localparam logic [15:0] GAP_INIT    = 16'(MOVE_GAP - 1);

    state_e      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [15:0] gap_q, gap_d;
    tap_t        cur_tap_q, cur_tap_d;
    tap_t        target_q, target_d;
    logic        busy_q, busy_d, done_q, done_d, fail_q, fail_d;
    tap_t        center_q, center_d, wlen_q, wlen_d;
    logic        clr_q, clr_d, load_q, load_d, move_q, move_d, dir_q, dir_d;
    logic        trk_init_s, trk_sample_s, trk_close_s, pass_s, sweep_end_s;
    tap_t        best_start_s, center_s;
    len_t        best_len_s;

    assign pass_s      = !bus.EYE_MONITOR_EARLY_0 && !bus.EYE_MONITOR_LATE_0;
    assign sweep_end_s = (cur_tap_q == LAST_TAP) || bus.DELAY_LINE_OUT_OF_RANGE_0;

    train_window_tracker u_tracker (
        .clk_i       (FAB_CLK),
        .rst_ni      (ARST_N),
        .init_i      (trk_init_s),
        .sample_i    (trk_sample_s),
        .pass_i      (pass_s),
        .close_i     (trk_close_s),
        .cur_tap_i   (cur_tap_q),
        .best_start_o(best_start_s),
        .best_len_o  (best_len_s),
        .center_o    (center_s)
    );

    // Next-state and registered-output decode for the sweep/return sequence.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        cur_tap_d    = cur_tap_q;
        target_d     = target_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        fail_d       = fail_q;
        center_d     = center_q;
        wlen_d       = wlen_q;
        clr_d        = 1'b0;
        load_d       = 1'b0;
        move_d       = 1'b0;
        dir_d        = dir_q;
        trk_init_s   = 1'b0;
        trk_sample_s = 1'b0;
        trk_close_s  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.START) begin
                    busy_d     = 1'b1;
                    fail_d     = 1'b0;
                    center_d   = tap_t'(1'b0);
                    wlen_d     = tap_t'(1'b0);
                    cur_tap_d  = tap_t'(1'b0);
                    trk_init_s = 1'b1;
                    state_d    = ST_LOAD;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_LOAD: begin
                load_d    = 1'b1;
                cur_tap_d = tap_t'(1'b0);
                state_d   = ST_CLEAR;
            end
            ST_CLEAR: begin
                clr_d   = 1'b1;
                cnt_d   = SETTLE_INIT;
                state_d = ST_SETTLE;
            end
            ST_SETTLE: begin
                if (cnt_q == 16'd0) begin
                    state_d = ST_SAMPLE;
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            ST_SAMPLE: begin
                trk_sample_s = 1'b1;
                if (sweep_end_s) begin
                    trk_close_s = 1'b1;
                    state_d     = ST_CALC;
                end else begin
                    dir_d   = DIR_INC;
                    state_d = ST_STEP;
                end
            end
            ST_STEP: begin
                if (gap_q == 16'd0) begin
                    move_d    = 1'b1;
                    cur_tap_d = cur_tap_q + tap_t'(1'b1);
                    state_d   = ST_CLEAR;
                end else begin
                    state_d = ST_STEP;
                end
            end
            ST_CALC: begin
                dir_d = DIR_DEC;
                // A centre outside its own window can only come from corrupted state.
                if ((best_len_s < MIN_LEN) || (center_s < best_start_s)) begin
                    fail_d    = 1'b1;
                    target_d  = tap_t'(1'b0);
                    load_d    = 1'b1;
                    cur_tap_d = tap_t'(1'b0);
                end else begin
                    target_d = center_s;
                end
                state_d = ST_RETURN;
            end
            ST_RETURN: begin
                if (cur_tap_q > target_q) begin
                    if (gap_q == 16'd0) begin
                        move_d    = 1'b1;
                        cur_tap_d = cur_tap_q - tap_t'(1'b1);
                    end else begin
                        move_d = 1'b0;
                    end
                end else begin
                    state_d = ST_FINISH;
                end
            end
            ST_FINISH: begin
                center_d = target_q;
                wlen_d   = best_len_s[TAP_W-1:0];
                done_d   = 1'b1;
                busy_d   = 1'b0;
                state_d  = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        if (move_d) begin
            gap_d = GAP_INIT;
        end else if (gap_q != 16'd0) begin
            gap_d = gap_q - 16'd1;
        end else begin
            gap_d = gap_q;
        end
    end

    // State, counters and registered outputs.
    always_ff @(posedge FAB_CLK or negedge ARST_N) begin
        if (!ARST_N) begin
            state_q   <= ST_IDLE;
            cnt_q     <= 16'd0;
            gap_q     <= 16'd0;
            cur_tap_q <= tap_t'(1'b0);
            target_q  <= tap_t'(1'b0);
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            fail_q    <= 1'b0;
            center_q  <= tap_t'(1'b0);
            wlen_q    <= tap_t'(1'b0);
            clr_q     <= 1'b0;
            load_q    <= 1'b0;
            move_q    <= 1'b0;
            dir_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            gap_q     <= gap_d;
            cur_tap_q <= cur_tap_d;
            target_q  <= target_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            fail_q    <= fail_d;
            center_q  <= center_d;
            wlen_q    <= wlen_d;
            clr_q     <= clr_d;
            load_q    <= load_d;
            move_q    <= move_d;
            dir_q     <= dir_d;
        end
    end

    assign bus.BUSY                      = busy_q;
    assign bus.DONE                      = done_q;
    assign bus.FAIL                      = fail_q;
    assign bus.TAP_CENTER                = center_q;
    assign bus.WINDOW_LEN                = wlen_q;
    assign bus.EYE_MONITOR_CLEAR_FLAGS_0 = clr_q;
    assign bus.DELAY_LINE_LOAD_0         = load_q;
    assign bus.DELAY_LINE_MOVE_0         = move_q;
    assign bus.DELAY_LINE_DIRECTION_0    = dir_q;

endmodule

// File: tb/tb_dq_read_eye_trainer.sv
// Directed bench for dq_read_eye_trainer: an IOD tap/eye model, a window-search reference model
// and a per-cycle monitor for pulse spacing, direction stability and reset behaviour.
module tb_dq_read_eye_trainer;

    localparam int MAX_TAPS = 128;
    localparam int SETTLE   = 8;
    localparam int GAP      = 4;
    localparam int MINW     = 4;

    logic clk    = 1'b0;
    logic arst_n = 1'b0;
    always #5 clk = ~clk;

    dq_read_eye_trainer_if bus ();

    dq_read_eye_trainer #(
        .MAX_TAPS     (MAX_TAPS),
        .SETTLE_CYCLES(SETTLE),
        .MOVE_GAP     (GAP),
        .MIN_WINDOW   (MINW)
    ) dut (
        .FAB_CLK(clk),
        .ARST_N (arst_n),
        .bus    (bus)
    );

    int checks   = 0;
    int failures = 0;

    int lo1 = -1, hi1 = -2, lo2 = -1, hi2 = -2, oor_at = 999, exp_end = 127;
    int iod_tap = 0;
    logic early_r = 1'b0, late_r = 1'b0;

    int cyc = 0, last_move = -1000, ups = 0, downs = 0, loads = 0, dones = 0;
    logic prev_dir = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    function automatic bit tap_pass(input int t);
        return (t >= lo1 && t <= hi1) || (t >= lo2 && t <= hi2);
    endfunction

    // IOD model: tap position follows LOAD/MOVE, sticky flags cleared by CLEAR_FLAGS.
    assign bus.EYE_MONITOR_EARLY_0       = early_r;
    assign bus.EYE_MONITOR_LATE_0        = late_r;
    assign bus.DELAY_LINE_OUT_OF_RANGE_0 = (iod_tap >= oor_at);

    always @(posedge clk) begin
        if (bus.DELAY_LINE_LOAD_0) iod_tap <= 0;
        else if (bus.DELAY_LINE_MOVE_0) iod_tap <= bus.DELAY_LINE_DIRECTION_0 ? iod_tap + 1 : iod_tap - 1;
        if (bus.EYE_MONITOR_CLEAR_FLAGS_0) begin
            early_r <= !tap_pass(iod_tap) && (iod_tap < 64);
            late_r  <= !tap_pass(iod_tap) && (iod_tap >= 64);
        end else begin
            early_r <= early_r | (!tap_pass(iod_tap) && (iod_tap < 64));
            late_r  <= late_r | (!tap_pass(iod_tap) && (iod_tap >= 64));
        end
    end

    // Reference: longest strictly-longer run over the swept taps, floor centre.
    task automatic model(output int c, output int wl, output bit f, output int up_n, output int dn_n);
        int bs = 0, bl = 0, t = 0, s;
        exp_end = (oor_at < MAX_TAPS - 1) ? oor_at : MAX_TAPS - 1;
        while (t <= exp_end) begin
            if (tap_pass(t)) begin
                s = t;
                while (t <= exp_end && tap_pass(t)) t++;
                if (t - s > bl) begin bl = t - s; bs = s; end
            end else begin
                t++;
            end
        end
        f    = (bl < MINW);
        c    = f ? 0 : bs + (bl - 1) / 2;
        wl   = bl;
        up_n = exp_end;
        dn_n = f ? 0 : exp_end - c;
    endtask

    // Per-cycle monitor.
    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (!arst_n) begin
                chk("reset_outputs_zero", int'({bus.BUSY, bus.DONE, bus.FAIL, bus.TAP_CENTER, bus.WINDOW_LEN,
                    bus.EYE_MONITOR_CLEAR_FLAGS_0, bus.DELAY_LINE_LOAD_0, bus.DELAY_LINE_MOVE_0,
                    bus.DELAY_LINE_DIRECTION_0}), 0);
            end else begin
                if (bus.DELAY_LINE_MOVE_0) begin
                    chk("move_gap_ok", int'(cyc - last_move >= GAP), 1);
                    chk("dir_stable", int'(bus.DELAY_LINE_DIRECTION_0), int'(prev_dir));
                    if (bus.DELAY_LINE_DIRECTION_0) begin
                        chk("no_move_past_end", int'(iod_tap < exp_end), 1);
                        ups++;
                    end else begin
                        downs++;
                    end
                    last_move = cyc;
                end
                if (bus.DELAY_LINE_LOAD_0) loads++;
                if (bus.DONE) begin
                    dones++;
                    chk("busy_low_at_done", int'(bus.BUSY), 0);
                end
            end
            prev_dir = bus.DELAY_LINE_DIRECTION_0;
        end
    end

    task automatic pulse_start();
        @(posedge clk);
        #1 bus.START = 1'b1;
        @(posedge clk);
        #1 bus.START = 1'b0;
        chk("busy_after_start", int'(bus.BUSY), 1);
    endtask

    task automatic run_scn(input string name, input int a_lo1, input int a_hi1, input int a_lo2,
                           input int a_hi2, input int a_oor, input int exp_c, input int exp_l,
                           input int exp_f, input int extra_start_at);
        int mc, ml, mu, md, u0, d0, l0, n0, k;
        bit mf, seen;
        lo1 = a_lo1; hi1 = a_hi1; lo2 = a_lo2; hi2 = a_hi2; oor_at = a_oor;
        model(mc, ml, mf, mu, md);
        chk({name, "_model_center"}, mc, exp_c);
        chk({name, "_model_len"}, ml, exp_l);
        u0 = ups; d0 = downs; l0 = loads; n0 = dones;
        pulse_start();
        seen = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk);
            if (bus.DELAY_LINE_LOAD_0 || bus.DELAY_LINE_MOVE_0) begin
                seen = 1'b1;
                chk({name, "_load_first"}, int'(bus.DELAY_LINE_LOAD_0), 1);
            end
        end
        if (!seen) chk({name, "_load_seen"}, 0, 1);
        k = 0;
        while (bus.DONE !== 1'b1 && k < 20000) begin
            @(negedge clk);
            k++;
            bus.START = (k == extra_start_at);
        end
        bus.START = 1'b0;
        chk({name, "_done_in_time"}, int'(k < 20000), 1);
        chk({name, "_tap_center"}, int'(bus.TAP_CENTER), exp_c);
        chk({name, "_window_len"}, int'(bus.WINDOW_LEN), exp_l);
        chk({name, "_fail"}, int'(bus.FAIL), exp_f);
        chk({name, "_fail_vs_model"}, int'(bus.FAIL), int'(mf));
        @(negedge clk);
        @(negedge clk);
        chk({name, "_done_one_cycle"}, int'(bus.DONE), 0);
        chk({name, "_center_held"}, int'(bus.TAP_CENTER), mc);
        chk({name, "_up_moves"}, ups - u0, mu);
        chk({name, "_down_moves"}, downs - d0, md);
        chk({name, "_loads"}, loads - l0, mf ? 2 : 1);
        chk({name, "_dones"}, dones - n0, 1);
        chk({name, "_parked_tap"}, iod_tap, mc);
    endtask

    initial begin
        int d0, tap_hold, k;
        bus.START = 1'b0;
        repeat (3) @(negedge clk);
        arst_n = 1'b1;
        @(negedge clk);
        chk("idle_busy", int'(bus.BUSY), 0);
        chk("idle_done", int'(bus.DONE), 0);

        run_scn("one_window",    40, 71, -1, -2, 999, 55, 32, 0, 0);
        run_scn("two_windows",   10, 19, 60, 79, 999, 69, 20, 0, 300);
        run_scn("equal_windows", 10, 19, 50, 59, 999, 14, 10, 0, 0);
        run_scn("short_window",   5,  7, -1, -2, 999,  0,  3, 1, 0);
        run_scn("out_of_range",  90, 999, -1, -2, 100, 95, 11, 0, 0);

        // Reset while walking back to the centre.
        lo1 = 40; hi1 = 71; lo2 = -1; hi2 = -2; oor_at = 999; exp_end = 127;
        d0 = downs;
        pulse_start();
        k = 0;
        while (downs - d0 < 10 && k < 20000) begin
            @(negedge clk);
            k++;
        end
        chk("return_reached", int'(k < 20000), 1);
        #2 arst_n = 1'b0;
        #1 chk("async_reset_outputs", int'({bus.BUSY, bus.DONE, bus.FAIL, bus.TAP_CENTER, bus.WINDOW_LEN,
               bus.EYE_MONITOR_CLEAR_FLAGS_0, bus.DELAY_LINE_LOAD_0, bus.DELAY_LINE_MOVE_0,
               bus.DELAY_LINE_DIRECTION_0}), 0);
        tap_hold = iod_tap;
        repeat (5) @(negedge clk);
        chk("tap_frozen_in_reset", iod_tap, tap_hold);
        arst_n = 1'b1;
        @(negedge clk);
        run_scn("after_reset", 40, 71, -1, -2, 999, 55, 32, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dq_read_eye_trainer.md
Name: dq_read_eye_trainer

Overview:
- Per-lane read-training engine that drives one DQ IOD delay-line/eye-monitor interface from the fabric side.
- Steps the DQ input delay across its range and samples the eye-monitor early/late flags at each tap.
- Finds the longest contiguous passing window and parks the delay at its centre.
- Sits in the DDR3 PHY training block, one instance per trained DQ bit; the sequencer starts it after DQS gate training.

Parameters:
- TAP_W, 8, width of tap counters and results.
- MAX_TAPS, 128, number of tap positions swept (0..MAX_TAPS-1); must be ≤ 2^TAP_W.
- SETTLE_CYCLES, 8, FAB_CLK cycles waited after a clear/move before sampling flags; must be ≥ 1.
- MOVE_GAP, 4, minimum FAB_CLK cycles between DELAY_LINE_MOVE pulses; must be ≥ 2.
- MIN_WINDOW, 4, minimum passing-window length; a shorter best window is a failure.

Ports:
- FAB_CLK, in, 1, fabric clock; all logic is on its rising edge.
- ARST_N, in, 1, asynchronous active-low reset.
- START, in, 1, single-cycle training request; ignored while BUSY=1.
- BUSY, out, 1, high from the cycle after START until DONE rises.
- DONE, out, 1, one-cycle completion pulse.
- FAIL, out, 1, sticky result flag: 1 if no window ≥ MIN_WINDOW; cleared by the next accepted START.
- TAP_CENTER, out, TAP_W, final tap position; valid when DONE=1 and held until the next START.
- WINDOW_LEN, out, TAP_W, length of the best window; held like TAP_CENTER.
- EYE_MONITOR_EARLY_0, in, 1, sticky early flag from the IOD.
- EYE_MONITOR_LATE_0, in, 1, sticky late flag from the IOD.
- EYE_MONITOR_CLEAR_FLAGS_0, out, 1, one-cycle pulse that clears both eye flags.
- DELAY_LINE_LOAD_0, out, 1, one-cycle pulse that reloads the delay line to its base tap (tap 0).
- DELAY_LINE_MOVE_0, out, 1, one-cycle pulse that moves the delay line by one tap.
- DELAY_LINE_DIRECTION_0, out, 1, 1 = increment delay, 0 = decrement; stable from one cycle before a MOVE pulse through that pulse.
- DELAY_LINE_OUT_OF_RANGE_0, in, 1, delay line at its limit.

Behaviour:
- Reset: all outputs are 0, the FSM is in IDLE, and all counters and results are 0.
- FSM states: IDLE, LOAD, CLEAR, SETTLE, SAMPLE, STEP, CALC, RETURN, FINISH.
- IDLE: on START, go to LOAD. Clear FAIL, cur_tap, run_start, run_len, best_start and best_len.
- LOAD: pulse DELAY_LINE_LOAD_0 for one cycle, set cur_tap=0, then go to CLEAR.
- CLEAR: pulse EYE_MONITOR_CLEAR_FLAGS_0 for one cycle, then go to SETTLE.
- SETTLE: wait SETTLE_CYCLES, then go to SAMPLE.
- SAMPLE (one cycle): pass = !EARLY & !LATE.
  - If pass: run_len++ (set run_start=cur_tap when run_len was 0).
  - If not pass: close the run.
  - Closing a run: if run_len > best_len, copy run_start/run_len into best_start/best_len, then clear run_len. On equal lengths the earlier window is kept.
  - Sweep end: cur_tap==MAX_TAPS-1, or DELAY_LINE_OUT_OF_RANGE_0=1 at this sample. Close the run and go to CALC.
  - Otherwise go to STEP.
- STEP: DIRECTION=1 is set one cycle ahead; pulse MOVE for one cycle; cur_tap++; go to CLEAR. Consecutive MOVE pulses are never closer than MOVE_GAP cycles.
- CALC (one cycle):
  - If best_len < MIN_WINDOW: FAIL=1, target=0, and pulse DELAY_LINE_LOAD_0 instead of walking back.
  - Else: target = best_start + ((best_len-1)>>1), floor; arithmetic is in TAP_W+1 bits with no overflow.
  - Go to RETURN.
- RETURN: while cur_tap > target, hold DIRECTION=0, pulse MOVE, cur_tap--, spacing pulses by MOVE_GAP. The eye flags are not sampled. When cur_tap==target, go to FINISH.
- FINISH: set TAP_CENTER=target (0 on fail), WINDOW_LEN=best_len, pulse DONE, drop BUSY, go to IDLE.
- A passing run still open at sweep end is closed before CALC.
- OUT_OF_RANGE asserted outside SAMPLE is ignored.
- START pulses during BUSY have no effect.
- ARST_N asserted mid-operation returns the block to reset state immediately. No further MOVE or LOAD pulses are issued, and the IOD tap is left as-is for the next run's LOAD.

Decomposition:
- Shared package ddr_train_pkg holds:
  - state enum for the FSM;
  - DIR_INC=1'b1, DIR_DEC=1'b0;
  - the tap_t typedef, sized by TAP_W.
- One natural sub-module, train_window_tracker: run/best window bookkeeping plus the centre calculation. Inputs: sample strobe, pass, cur_tap, close. Outputs: best_start, best_len, center.

Test Plan:
- Eye model passes taps 40..71, MAX_TAPS=128 → 127 up-moves, then 127-55=72 down-moves; DONE with TAP_CENTER=55, WINDOW_LEN=32, FAIL=0.
- Two windows, 10..19 and 60..79 → best is 60..79, TAP_CENTER=69, WINDOW_LEN=20.
- Equal windows, 10..19 and 50..59 → earlier window wins, TAP_CENTER=14, WINDOW_LEN=10.
- Pass only at taps 5..7 (length 3 < MIN_WINDOW=4) → FAIL=1, a final LOAD pulse, TAP_CENTER=0, WINDOW_LEN=3.
- Pass for taps ≥ 90 with OUT_OF_RANGE asserted at tap 100 → sweep stops at 100, window 90..100, TAP_CENTER=95, WINDOW_LEN=11, no MOVE beyond tap 100.
- ARST_N low during RETURN → all outputs 0 within the same cycle; a later START restarts cleanly with LOAD first. Across all scenarios, a checker asserts MOVE gap ≥ MOVE_GAP and that DIRECTION is stable around every MOVE pulse.
